// File: rtl/alu_muldiv_if.sv
// alu_muldiv_if: request/result bundle between the ALU and the multiply/divide engine
interface alu_muldiv_if #(parameter int WIDTH = 8);
  logic start;
  logic op;
  logic signed_mode;
  logic high;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic done;
  logic [WIDTH-1:0] result;
  logic div_zero;
  modport master (output start, op, signed_mode, high, a, b, input done, result, div_zero);
  modport slave (input start, op, signed_mode, high, a, b, output done, result, div_zero);
endinterface

// File: rtl/alu_muldiv.sv
// alu_muldiv: iterative shift-add multiply / restoring divide engine, one bit per cycle
module alu_muldiv #(parameter int WIDTH = 8) (
  input logic clk,
  input logic rst,
  alu_muldiv_if.slave bus
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, LOAD, ITER, FIX} state_t;
  state_t state, state_n;
  logic rop, rsg, rhi, sa, sb, fix2, ge, neg, bz;
  logic [WIDTH-1:0] ra, rb, mag_a, mag_b, rem_n;
  logic [2*WIDTH-1:0] acc, addend, fixed;
  logic [CW-1:0] cnt;
  logic [WIDTH:0] sh, df;
  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state: LOAD and the two FIX cycles bracket exactly WIDTH iterations
  always_comb begin
    state_n = state;
    case (state)
      IDLE: state_n = bus.start ? LOAD : IDLE;
      LOAD: state_n = ITER;
      ITER: state_n = (cnt == CW'(WIDTH - 1)) ? FIX : ITER;
      FIX: state_n = fix2 ? IDLE : FIX;
      default: state_n = IDLE;
    endcase
  end
  // one iteration step and sign fix-up; acc holds the product or {remainder, quotient}
  always_comb begin
    sh = {acc[2*WIDTH-1:WIDTH], mag_a[CW'(WIDTH - 1) - cnt]};
    df = sh - {1'b0, mag_b};
    ge = sh >= {1'b0, mag_b};
    rem_n = ge ? df[WIDTH-1:0] : sh[WIDTH-1:0];
    addend = mag_b[cnt] ? ({{WIDTH{1'b0}}, mag_a} << cnt) : '0;
    neg = rsg & (sa ^ sb);
    bz = rb == '0;
    fixed = !rop ? (neg ? -acc : acc) :
            bz ? {ra, {WIDTH{1'b1}}} :
            {(rsg & sa) ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH],
             neg ? -acc[WIDTH-1:0] : acc[WIDTH-1:0]};
  end
  // capture, magnitude load, iterate, then correct signs and publish
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      {rop, rsg, rhi, sa, sb, fix2} <= '0;
      {ra, rb, mag_a, mag_b} <= '0;
      acc <= '0;
      cnt <= '0;
      bus.result <= '0;
      bus.div_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          rop <= bus.op;
          rsg <= bus.signed_mode;
          rhi <= bus.high;
          ra <= bus.a;
          rb <= bus.b;
        end
        LOAD: begin
          mag_a <= (rsg & ra[WIDTH-1]) ? -ra : ra;
          mag_b <= (rsg & rb[WIDTH-1]) ? -rb : rb;
          sa <= rsg & ra[WIDTH-1];
          sb <= rsg & rb[WIDTH-1];
          cnt <= '0;
          acc <= '0;
          fix2 <= 1'b0;
        end
        ITER: begin
          acc <= rop ? {rem_n, acc[WIDTH-2:0], ge} : acc + addend;
          cnt <= cnt + 1'b1;
        end
        FIX: if (!fix2) begin
          acc <= fixed;
          fix2 <= 1'b1;
        end else begin
          bus.result <= rhi ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
          bus.div_zero <= rop & bz;
        end
        default: ;
      endcase
    end
  // done is registered and tracks arrival in IDLE, so it is low during reset
  always_ff @(posedge clk or posedge rst)
    if (rst) bus.done <= 1'b0;
    else bus.done <= state_n == IDLE;
endmodule

// File: tb/tb_alu_muldiv.sv
// tb_alu_muldiv: directed vectors checked against a cycle-level arithmetic model
module tb_alu_muldiv;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  alu_muldiv_if #(.WIDTH(8)) bus ();
  alu_muldiv #(.WIDTH(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  int nc = 0;
  int nm = 0;
  int rem;
  logic exp_done, exp_dz, pend_dz;
  logic [7:0] exp_res, pend_res;
  // reference arithmetic: returns {div_zero, result}
  function automatic logic [8:0] model(input logic op, sg, hi, input logic [7:0] a, b);
    int x, y, p, q, r;
    logic [15:0] pv;
    logic [7:0] qv, rv;
    x = sg ? int'($signed(a)) : int'(a);
    y = sg ? int'($signed(b)) : int'(b);
    if (!op) begin
      p = x * y;
      pv = p[15:0];
      return {1'b0, hi ? pv[15:8] : pv[7:0]};
    end
    if (b == 8'h00) return {1'b1, hi ? a : 8'hFF};
    q = x / y;
    r = x % y;
    qv = q[7:0];
    rv = r[7:0];
    return {1'b0, hi ? rv : qv};
  endfunction
  // expected outputs: idle/busy with a fixed 11-edge latency
  always @(posedge clk or posedge rst)
    if (rst) begin
      exp_done <= 1'b0;
      exp_res <= 8'h00;
      exp_dz <= 1'b0;
      rem <= 0;
    end else if (rem == 0) begin
      if (bus.start) begin
        {pend_dz, pend_res} <= model(bus.op, bus.signed_mode, bus.high, bus.a, bus.b);
        rem <= 11;
        exp_done <= 1'b0;
      end else exp_done <= 1'b1;
    end else begin
      rem <= rem - 1;
      if (rem == 1) begin
        exp_done <= 1'b1;
        exp_res <= pend_res;
        exp_dz <= pend_dz;
      end
    end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    nc++;
    if (act !== want) begin
      nm++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
    end
  endtask
  task automatic step();
    @(negedge clk);
    chk("done", {31'd0, bus.done}, {31'd0, exp_done});
    chk("result", {24'd0, bus.result}, {24'd0, exp_res});
    chk("div_zero", {31'd0, bus.div_zero}, {31'd0, exp_dz});
  endtask
  task automatic issue(input logic op, sg, hi, input logic [7:0] a, b);
    bus.op = op;
    bus.signed_mode = sg;
    bus.high = hi;
    bus.a = a;
    bus.b = b;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask
  task automatic wait_done(output int n);
    n = 0;
    while (!bus.done && n < 30) begin
      n++;
      step();
    end
    chk("timeout", {31'd0, n < 30}, 32'd1);
  endtask
  task automatic run(input string name, input logic op, sg, hi, input logic [7:0] a, b,
                     input logic [7:0] want, input logic want_dz);
    int lat;
    issue(op, sg, hi, a, b);
    wait_done(lat);
    chk({name, "_lat"}, lat, 32'd11);
    chk(name, {24'd0, bus.result}, {24'd0, want});
    chk({name, "_dz"}, {31'd0, bus.div_zero}, {31'd0, want_dz});
  endtask
  initial begin
    int n;
    bus.start = 1'b0;
    bus.op = 1'b0;
    bus.signed_mode = 1'b0;
    bus.high = 1'b0;
    bus.a = 8'h00;
    bus.b = 8'h00;
    repeat (2) step();
    chk("reset_done", {31'd0, bus.done}, 32'd0);
    rst = 1'b0;
    step();
    chk("first_done", {31'd0, bus.done}, 32'd1);
    run("umul_lo", 0, 0, 0, 8'd200, 8'd3, 8'h58, 0);
    run("umul_hi", 0, 0, 1, 8'd200, 8'd3, 8'h02, 0);
    run("smul_lo", 0, 1, 0, 8'hFD, 8'h05, 8'hF1, 0);
    run("smul_hi", 0, 1, 1, 8'hFD, 8'h05, 8'hFF, 0);
    run("umul_fd", 0, 0, 1, 8'hFD, 8'h05, 8'h04, 0);
    run("udiv_q", 1, 0, 0, 8'd200, 8'd7, 8'h1C, 0);
    run("udiv_r", 1, 0, 1, 8'd200, 8'd7, 8'h04, 0);
    run("sdiv_q1", 1, 1, 0, 8'hF9, 8'h02, 8'hFD, 0);
    run("sdiv_r1", 1, 1, 1, 8'hF9, 8'h02, 8'hFF, 0);
    run("sdiv_q2", 1, 1, 0, 8'h07, 8'hFE, 8'hFD, 0);
    run("sdiv_r2", 1, 1, 1, 8'h07, 8'hFE, 8'h01, 0);
    run("dz_q", 1, 0, 0, 8'h2A, 8'h00, 8'hFF, 1);
    run("dz_r", 1, 1, 1, 8'h2A, 8'h00, 8'h2A, 1);
    run("mul_clr", 0, 0, 0, 8'd2, 8'd2, 8'h04, 0);
    run("ovf_q", 1, 1, 0, 8'h80, 8'hFF, 8'h80, 0);
    run("ovf_r", 1, 1, 1, 8'h80, 8'hFF, 8'h00, 0);
    issue(0, 0, 0, 8'd200, 8'd3);
    repeat (3) step();
    bus.op = 1'b1;
    bus.a = 8'h01;
    bus.b = 8'h01;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    wait_done(n);
    chk("busy_ignore", {24'd0, bus.result}, 32'h58);
    issue(1, 0, 0, 8'd200, 8'd7);
    repeat (5) step();
    rst = 1'b1;
    step();
    chk("rst_done", {31'd0, bus.done}, 32'd0);
    chk("rst_result", {24'd0, bus.result}, 32'd0);
    rst = 1'b0;
    step();
    chk("rst_redone", {31'd0, bus.done}, 32'd1);
    run("post_rst", 1, 0, 0, 8'd200, 8'd7, 8'h1C, 0);
    bus.op = 1'b0;
    bus.signed_mode = 1'b1;
    bus.high = 1'b0;
    bus.a = 8'hFD;
    bus.b = 8'h05;
    bus.start = 1'b1;
    repeat (24) step();
    bus.start = 1'b0;
    wait_done(n);
    chk("b2b", {24'd0, bus.result}, 32'hF1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nc, nm);
    $finish;
  end
endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Iterative 8-bit multiply/divide engine serving the ALU's multiply and divide selects (cselect 2/3). The ALU asserts `start` with its post-invert operands (xora/xorb), `signed_mode` and `high`, waits for `done`, then latches `result` into its output mux. Shift-add multiply and restoring divide, one bit per cycle, so the ALU needs no combinational multiplier or divider.

## Interface
- `WIDTH`, 8, operand/result width; iteration count equals WIDTH.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = multiply, 1 = divide.
- `signed_mode`  in  1  operands are two's complement when 1.
- `high`  in  1  mul: select product[15:8]; div: select remainder.
- `a`  in  WIDTH  multiplicand / dividend.
- `b`  in  WIDTH  multiplier / divisor.
- `done`  out  1  high in IDLE (ready / result valid), low while busy.
- `result`  out  WIDTH  selected result byte, held until next completion.
- `div_zero`  out  1  last completed divide had b == 0; held like `result`.

## Operation
- States: IDLE, LOAD, ITER, FIX.
- IDLE: `done` = 1. `start` = 1 → capture `a`, `b`, `op`, `signed_mode`, `high`; go LOAD; `done` = 0. Later input changes are ignored until the next IDLE.
- LOAD: form magnitudes (negate when signed and MSB set), record sign_a, sign_b, set count = 0, clear accumulator; go ITER.
- ITER, multiply: 16-bit shift-add, one multiplier bit per cycle, LSB first.
- ITER, divide: restoring. Shift remainder left, bring in the next dividend bit (MSB first), subtract divisor; on non-negative keep and set quotient bit to 1, else restore and set it to 0.
- ITER runs exactly WIDTH cycles (count 0..WIDTH-1), then go FIX.
- FIX:
  - Sign correction when signed: product negated if sign_a ^ sign_b; quotient negated if sign_a ^ sign_b; remainder negated if sign_a. Division truncates toward zero.
  - Select the byte per `high` into `result`, update `div_zero`, go IDLE, `done` = 1.
- Divide by zero (b == 0): full latency, no sign correction. Quotient = all ones (0xFF); remainder = `a` as captured (raw bits); `div_zero` = 1.
- Signed overflow -128 / -1: quotient wraps to 0x80, remainder 0x00, `div_zero` = 0.
- Multiply never overflows; all 16 product bits are kept internally.
- Any multiply completion clears `div_zero`.
- `start` outside IDLE is ignored; no queueing.

## Timing
- Reset: state IDLE, `done` = 0, `result` = 0, `div_zero` = 0. `done` rises on the first clock edge after `rst` falls. `start` is accepted on that same first edge.
- Latency, with the start-sampling edge as E0:
  - E0: enter LOAD, `done` falls.
  - E1: enter ITER.
  - E2..E9: eight iterations.
  - E10: FIX.
  - E11: `result`/`div_zero` updated and `done` = 1 together.
- Total 11 edges from acceptance to valid; the same for every op, sign and operand value.
- `start` held high across E11 is re-accepted at E12 (back-to-back).
- `rst` mid-operation returns to IDLE immediately. Partial state is discarded; `result`/`div_zero` reset to 0.
- Outputs are registered; no combinational path from inputs to `done`/`result`.

## Test plan
- Unsigned mul 200 × 3 (0x0258): high=0 → 0x58, high=1 → 0x02. `done` low for exactly 11 edges, then high.
- Signed mul −3 × 5 (0xFD × 0x05 = 0xFFF1): high=0 → 0xF1, high=1 → 0xFF. Unsigned same operands, high=1 → 0x04.
- Unsigned div 200 / 7 → 0x1C, remainder 0x04. Signed −7 / 2 → 0xFD, remainder 0xFF. Signed 7 / −2 → 0xFD, remainder 0x01.
- Div by zero, a = 0x2A, b = 0: result 0xFF, `div_zero` = 1; high=1 → 0x2A. Following mul 2 × 2 → 0x04, `div_zero` = 0.
- Signed 0x80 / 0xFF → 0x80, remainder 0x00, `div_zero` = 0.
- `start` pulsed at E4 of a busy op: ignored, result unchanged. `rst` at E6: `done` = 0, `result` = 0, then `done` = 1 next edge. A new op issued on that edge completes with the correct value.
